// File: rtl/ahb_regfile_bridge.sv
// AHB-Lite slave front end for the generated register file: posted zero-wait writes,
// reads stalled until the regfile answers, two-cycle ERROR for illegal or timed-out transfers.
//
// Handshakes: an AHB transfer is accepted when hsel & htrans[1] & hready are high at a rising
// edge while hreadyout=1. wr_en and rd_en are single-cycle strobes. rdata is taken only on a
// cycle with rd_rdy=1 while the FSM is in RD_WAIT; rd_rdy in any other state is ignored.
module ahb_regfile_bridge #(
   parameter logic [15:0] ADDR_SPAN   = 16'h1000,
   parameter int          TIMEOUT_CYC = 16
) (
   input  logic        clk,
   input  logic        rstb,
   input  logic        hsel,
   input  logic [31:0] haddr,
   input  logic [1:0]  htrans,
   input  logic        hwrite,
   input  logic [2:0]  hsize,
   input  logic [31:0] hwdata,
   input  logic        hready,
   output logic        hreadyout,
   output logic        hresp,
   output logic [31:0] hrdata,
   output logic        wr_en,
   output logic [3:0]  be,
   output logic [15:0] wr_addr,
   output logic [31:0] wdata,
   output logic        rd_en,
   output logic [15:0] rd_addr,
   input  logic [31:0] rdata,
   input  logic        rd_rdy,
   output logic [2:0]  dbg_state
);

   localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WR_DATA = 3'd1,
      RD_REQ  = 3'd2,
      RD_WAIT = 3'd3,
      RD_DONE = 3'd4,
      ERR1    = 3'd5,
      ERR2    = 3'd6
   } state_t;

   state_t        state_q, state_d;
   logic [13:0]   addr_q, addr_d;
   logic [3:0]    be_lat_q, be_lat_d;
   logic          wr_en_q, wr_en_d;
   logic [3:0]    be_q, be_d;
   logic [15:0]   wr_addr_q, wr_addr_d;
   logic [31:0]   wdata_q, wdata_d;
   logic [31:0]   hrdata_q, hrdata_d;
   logic [CW-1:0] cnt_q, cnt_d;

   logic [3:0]    be_dec;
   logic          legal;
   logic          unused_htrans0;

   assign unused_htrans0 = htrans[0];

   always_comb begin
      hreadyout = 1'b1;
      hresp     = 1'b0;
      rd_en     = 1'b0;
      state_d   = state_q;
      addr_d    = addr_q;
      be_lat_d  = be_lat_q;
      wr_en_d   = 1'b0;
      be_d      = be_q;
      wr_addr_d = wr_addr_q;
      wdata_d   = wdata_q;
      hrdata_d  = hrdata_q;
      cnt_d     = cnt_q;

      be_dec = 4'h0;
      legal  = 1'b1;
      case (hsize)
         3'd0: be_dec = 4'b0001 << haddr[1:0];
         3'd1: begin
            be_dec = 4'b0011 << haddr[1:0];
            if (haddr[0]) legal = 1'b0;
         end
         3'd2: begin
            be_dec = 4'hF;
            if (haddr[1:0] != 2'b00) legal = 1'b0;
         end
         default: legal = 1'b0;
      endcase
      if (haddr[31:16] != 16'h0 || haddr[15:0] >= ADDR_SPAN) legal = 1'b0;

      case (state_q)
         IDLE: state_d = IDLE;
         WR_DATA: begin
            // Posted write: data phase completes now, regfile strobe fires next cycle.
            wr_en_d   = 1'b1;
            be_d      = be_lat_q;
            wr_addr_d = {addr_q, 2'b00};
            wdata_d   = hwdata;
            state_d   = IDLE;
         end
         RD_REQ: begin
            hreadyout = 1'b0;
            // Hold off one cycle behind a strobing write so the read sees its result.
            if (!wr_en_q) begin
               rd_en   = 1'b1;
               cnt_d   = '0;
               state_d = RD_WAIT;
            end
         end
         RD_WAIT: begin
            hreadyout = 1'b0;
            if (rd_rdy) begin
               hrdata_d = rdata;
               state_d  = RD_DONE;
            end else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
               state_d = ERR1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         RD_DONE: state_d = IDLE;
         ERR1: begin
            hreadyout = 1'b0;
            hresp     = 1'b1;
            state_d   = ERR2;
         end
         ERR2: begin
            hresp   = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (hreadyout && hsel && htrans[1] && hready) begin
         addr_d   = haddr[15:2];
         be_lat_d = be_dec;
         if (!legal)      state_d = ERR1;
         else if (hwrite) state_d = WR_DATA;
         else             state_d = RD_REQ;
      end
   end

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         be_lat_q  <= '0;
         wr_en_q   <= 1'b0;
         be_q      <= '0;
         wr_addr_q <= '0;
         wdata_q   <= '0;
         hrdata_q  <= '0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         be_lat_q  <= be_lat_d;
         wr_en_q   <= wr_en_d;
         be_q      <= be_d;
         wr_addr_q <= wr_addr_d;
         wdata_q   <= wdata_d;
         hrdata_q  <= hrdata_d;
         cnt_q     <= cnt_d;
      end
   end

   assign wr_en     = wr_en_q;
   assign be        = be_q;
   assign wr_addr   = wr_addr_q;
   assign wdata     = wdata_q;
   assign hrdata    = hrdata_q;
   assign rd_addr   = {addr_q, 2'b00};
   assign dbg_state = state_q;

endmodule

// File: tb/tb_ahb_regfile_bridge.sv
// Directed bench for ahb_regfile_bridge: writes, reads, back-to-back ordering, error
// responses, read timeout and asynchronous reset, checked cycle by cycle.
module tb_ahb_regfile_bridge;

   logic        clk = 1'b0;
   logic        rstb;
   logic        hsel;
   logic [31:0] haddr;
   logic [1:0]  htrans;
   logic        hwrite;
   logic [2:0]  hsize;
   logic [31:0] hwdata;
   logic        hready;
   logic        hreadyout;
   logic        hresp;
   logic [31:0] hrdata;
   logic        wr_en;
   logic [3:0]  be;
   logic [15:0] wr_addr;
   logic [31:0] wdata;
   logic        rd_en;
   logic [15:0] rd_addr;
   logic [31:0] rdata;
   logic        rd_rdy;
   logic [2:0]  dbg_state;

   int n_assert = 0;
   int n_fail   = 0;

   localparam logic [2:0] S_IDLE = 3'd0, S_WR = 3'd1, S_RREQ = 3'd2, S_RWAIT = 3'd3,
                          S_RDONE = 3'd4, S_ERR1 = 3'd5, S_ERR2 = 3'd6;

   // Single-slave bus: the interconnect returns our own hreadyout as hready.
   assign hready = hreadyout;

   always #5 clk = ~clk;

   ahb_regfile_bridge dut (
      .clk(clk), .rstb(rstb), .hsel(hsel), .haddr(haddr), .htrans(htrans),
      .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hready(hready),
      .hreadyout(hreadyout), .hresp(hresp), .hrdata(hrdata), .wr_en(wr_en),
      .be(be), .wr_addr(wr_addr), .wdata(wdata), .rd_en(rd_en), .rd_addr(rd_addr),
      .rdata(rdata), .rd_rdy(rd_rdy), .dbg_state(dbg_state)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_bus();
      hsel   = 1'b0;
      htrans = 2'b00;
   endtask

   task automatic addr_phase(input logic [31:0] a, input logic w, input logic [2:0] s);
      hsel   = 1'b1;
      htrans = 2'b10;
      haddr  = a;
      hwrite = w;
      hsize  = s;
   endtask

   initial begin
      rstb   = 1'b0;
      hsel   = 1'b0;
      haddr  = '0;
      htrans = 2'b00;
      hwrite = 1'b0;
      hsize  = 3'd0;
      hwdata = '0;
      rdata  = '0;
      rd_rdy = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_hreadyout", hreadyout, 1);
      chk("rst_hresp", hresp, 0);
      chk("rst_wr_en", wr_en, 0);
      chk("rst_rd_en", rd_en, 0);
      chk("rst_state", dbg_state, S_IDLE);
      rstb = 1'b1;
      step();

      // Word write 0x12345678 to 0x0008
      addr_phase(32'h8, 1'b1, 3'd2);
      step();
      chk("w1_state", dbg_state, S_WR);
      chk("w1_hreadyout", hreadyout, 1);
      chk("w1_wr_en_early", wr_en, 0);
      idle_bus();
      hwdata = 32'h12345678;
      step();
      chk("w1_wr_en", wr_en, 1);
      chk("w1_be", be, 4'hF);
      chk("w1_wr_addr", wr_addr, 16'h0008);
      chk("w1_wdata", wdata, 32'h12345678);
      step();
      chk("w1_wr_en_one", wr_en, 0);

      // Back-to-back byte write to 0x000B, half write to 0x0006
      addr_phase(32'hB, 1'b1, 3'd0);
      step();
      addr_phase(32'h6, 1'b1, 3'd1);
      hwdata = 32'hEF000000;
      step();
      chk("wb_wr_en", wr_en, 1);
      chk("wb_be", be, 4'b1000);
      chk("wb_wr_addr", wr_addr, 16'h0008);
      chk("wb_wdata", wdata, 32'hEF000000);
      idle_bus();
      hwdata = 32'hBEEF0000;
      step();
      chk("wh_wr_en", wr_en, 1);
      chk("wh_be", be, 4'b1100);
      chk("wh_wr_addr", wr_addr, 16'h0004);
      chk("wh_wdata", wdata, 32'hBEEF0000);
      step();
      chk("wh_wr_en_one", wr_en, 0);

      // Read 0x0008, rd_rdy one cycle after rd_en; early rd_rdy must be ignored
      addr_phase(32'h8, 1'b0, 3'd2);
      step();
      chk("r1_hreadyout_ws1", hreadyout, 0);
      chk("r1_rd_en", rd_en, 1);
      chk("r1_rd_addr", rd_addr, 16'h0008);
      idle_bus();
      rd_rdy = 1'b1;
      rdata  = 32'hDEADBEEF;
      step();
      chk("r1_state_wait", dbg_state, S_RWAIT);
      chk("r1_hreadyout_ws2", hreadyout, 0);
      chk("r1_rd_en_one", rd_en, 0);
      rdata = 32'hCAFEF00D;
      step();
      chk("r1_hreadyout_done", hreadyout, 1);
      chk("r1_hresp", hresp, 0);
      chk("r1_hrdata", hrdata, 32'hCAFEF00D);
      rd_rdy = 1'b0;
      step();
      chk("r1_state_idle", dbg_state, S_IDLE);

      // Write 0xA5 to 0x0004 then read 0x0004 back-to-back
      addr_phase(32'h4, 1'b1, 3'd2);
      step();
      addr_phase(32'h4, 1'b0, 3'd2);
      hwdata = 32'h000000A5;
      step();
      chk("wr_rd_wr_en", wr_en, 1);
      chk("wr_rd_wdata", wdata, 32'h000000A5);
      chk("wr_rd_rd_en_held", rd_en, 0);
      chk("wr_rd_state", dbg_state, S_RREQ);
      chk("wr_rd_hreadyout", hreadyout, 0);
      idle_bus();
      step();
      chk("wr_rd_wr_en_off", wr_en, 0);
      chk("wr_rd_rd_en", rd_en, 1);
      chk("wr_rd_rd_addr", rd_addr, 16'h0004);
      step();
      chk("wr_rd_wait", dbg_state, S_RWAIT);
      rd_rdy = 1'b1;
      rdata  = 32'h000000A5;
      step();
      chk("wr_rd_done", hreadyout, 1);
      chk("wr_rd_hrdata", hrdata, 32'h000000A5);
      rd_rdy = 1'b0;
      step();

      // Misaligned half write to 0x0001
      addr_phase(32'h1, 1'b1, 3'd1);
      step();
      chk("e1_state", dbg_state, S_ERR1);
      chk("e1_c1_hreadyout", hreadyout, 0);
      chk("e1_c1_hresp", hresp, 1);
      idle_bus();
      step();
      chk("e1_c2_hreadyout", hreadyout, 1);
      chk("e1_c2_hresp", hresp, 1);
      chk("e1_wr_en", wr_en, 0);
      step();
      chk("e1_after_hresp", hresp, 0);
      chk("e1_after_wr_en", wr_en, 0);

      // Out-of-range read at ADDR_SPAN, then a write accepted during ERR2
      addr_phase(32'h1000, 1'b0, 3'd2);
      step();
      chk("e2_c1_hreadyout", hreadyout, 0);
      chk("e2_c1_hresp", hresp, 1);
      chk("e2_c1_rd_en", rd_en, 0);
      idle_bus();
      step();
      chk("e2_c2_hreadyout", hreadyout, 1);
      chk("e2_c2_hresp", hresp, 1);
      chk("e2_c2_rd_en", rd_en, 0);
      addr_phase(32'hC, 1'b1, 3'd2);
      step();
      chk("e2w_state", dbg_state, S_WR);
      chk("e2w_hresp", hresp, 0);
      idle_bus();
      hwdata = 32'h55AA55AA;
      step();
      chk("e2w_wr_en", wr_en, 1);
      chk("e2w_wr_addr", wr_addr, 16'h000C);
      chk("e2w_wdata", wdata, 32'h55AA55AA);
      step();

      // Nonzero upper address bits
      addr_phase(32'h0001_0008, 1'b0, 3'd2);
      step();
      chk("e3_state", dbg_state, S_ERR1);
      chk("e3_rd_en", rd_en, 0);
      idle_bus();
      step();
      step();

      // Read timeout with rd_rdy held low
      addr_phase(32'h10, 1'b0, 3'd2);
      step();
      chk("to_rd_en", rd_en, 1);
      chk("to_rd_addr", rd_addr, 16'h0010);
      idle_bus();
      for (int i = 0; i < 16; i++) begin
         step();
         chk($sformatf("to_wait_%0d", i), {hreadyout, dbg_state}, {1'b0, S_RWAIT});
      end
      step();
      chk("to_err1_state", dbg_state, S_ERR1);
      chk("to_err1_hreadyout", hreadyout, 0);
      chk("to_err1_hresp", hresp, 1);
      chk("to_hrdata_kept", hrdata, 32'h000000A5);
      step();
      chk("to_err2_hreadyout", hreadyout, 1);
      chk("to_err2_hresp", hresp, 1);
      rd_rdy = 1'b1;
      rdata  = 32'h00000BAD;
      step();
      chk("late_rdy_state", dbg_state, S_IDLE);
      chk("late_rdy_hrdata", hrdata, 32'h000000A5);
      rd_rdy = 1'b0;
      step();

      // Asynchronous reset in the middle of RD_WAIT
      addr_phase(32'h8, 1'b0, 3'd2);
      step();
      idle_bus();
      step();
      step();
      chk("ar_pre_state", dbg_state, S_RWAIT);
      rstb = 1'b0;
      #1;
      chk("ar_state", dbg_state, S_IDLE);
      chk("ar_hreadyout", hreadyout, 1);
      chk("ar_hresp", hresp, 0);
      chk("ar_hrdata", hrdata, 0);
      chk("ar_wr_en", wr_en, 0);
      chk("ar_rd_en", rd_en, 0);
      chk("ar_be", be, 0);
      chk("ar_wr_addr", wr_addr, 0);
      chk("ar_wdata", wdata, 0);
      chk("ar_rd_addr", rd_addr, 0);
      @(negedge clk);
      rstb = 1'b1;
      step();
      chk("ar_post_state", dbg_state, S_IDLE);
      chk("ar_post_hreadyout", hreadyout, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/ahb_regfile_bridge.md
Name: ahb_regfile_bridge

Overview:
AHB-Lite slave that converts bus transfers into the single-cycle write strobe and read-request/ready interface of the generated register file. Sits directly upstream of the regfile; its outputs drive regfile wr_en/be/wr_addr/wdata/rd_en/rd_addr, and it consumes rdata/rd_rdy. Posts writes with zero wait states, stalls reads until rd_rdy, and returns ERROR for illegal or timed-out transfers.

Parameters:
ADDR_SPAN, 16'h1000, byte span decoded by the regfile; haddr[15:0] >= ADDR_SPAN or haddr[31:16] != 0 -> ERROR
TIMEOUT_CYC, 16, max cycles spent waiting for rd_rdy after rd_en before an ERROR response

Ports:
clk  in  1  clock
rstb  in  1  reset
hsel  in  1  slave select
haddr  in  32  byte address
htrans  in  2  transfer type; only NONSEQ(2'b10) and SEQ(2'b11) start a transfer
hwrite  in  1  1=write
hsize  in  3  0=byte, 1=half, 2=word
hwdata  in  32  write data (data phase)
hready  in  1  bus ready; address phase sampled only when 1
hreadyout  out  1  slave ready
hresp  out  1  0=OKAY, 1=ERROR
hrdata  out  32  read data, valid when hreadyout=1 in a read data phase
wr_en  out  1  regfile write strobe, one cycle per write
be  out  4  byte enables
wr_addr  out  16  word-aligned write address
wdata  out  32  write data
rd_en  out  1  regfile read request, one cycle per read
rd_addr  out  16  word-aligned read address
rdata  in  32  regfile read data, valid with rd_rdy
rd_rdy  in  1  regfile read ready

Behaviour:
- Reset asynchronous on rstb low: hreadyout=1, hresp=0, hrdata=0, wr_en=0, rd_en=0, be=0, wr_addr=0, wdata=0, rd_addr=0; FSM=IDLE; pending write flag cleared; any in-flight read discarded.
- Accept: hsel & htrans[1] & hready at a rising edge latches haddr, hwrite, hsize. hsel=0 or IDLE/BUSY -> OKAY, zero wait.
- Decode: hsize=0 -> be=4'b0001<<haddr[1:0]; hsize=1 needs haddr[0]=0, be=4'b0011<<haddr[1:0]; hsize=2 needs haddr[1:0]=0, be=4'hF. Misalignment, hsize>2, or out of range -> ERROR, no regfile access.
- Addresses: wr_addr/rd_addr = {haddr[15:2],2'b00}.
- States: IDLE, WR_DATA, RD_REQ, RD_WAIT, RD_DONE, ERR1, ERR2.
- Write: address phase at edge A -> WR_DATA in cycle A+1, hreadyout=1, OKAY (posted). At edge A+1 capture hwdata, set pending flag; wr_en=1 with be/wr_addr/wdata during cycle A+2 only. Back-to-back writes give one wr_en per cycle.
- Read: address phase at edge A -> RD_REQ, hreadyout=0. rd_en=1 for exactly one cycle in A+1, or in A+2 if a posted wr_en is active in A+1 (the read always observes the preceding write). Then RD_WAIT, hreadyout=0, counting cycles. rd_rdy=1 -> hrdata<=rdata, RD_DONE: hreadyout=1, OKAY for one cycle, then IDLE or next accepted transfer. Nominal: rd_en A+1, rd_rdy A+2, data A+3 (2 wait states).
- Timeout: TIMEOUT_CYC cycles in RD_WAIT without rd_rdy -> ERR1; hrdata unchanged; late rd_rdy ignored.
- Error, two-cycle AHB response: ERR1 hreadyout=0 hresp=1; ERR2 hreadyout=1 hresp=1; then IDLE. A transfer accepted in ERR2 is processed normally.
- rd_rdy while not in RD_WAIT is ignored. wr_en and rd_en never assert in the same cycle.

Test Plan:
- Word write 0x12345678 to 0x0008, hsize=2 -> hreadyout stays 1; two cycles after the address phase wr_en=1 for 1 cycle, be=4'hF, wr_addr=0x0008, wdata=0x12345678.
- Byte write to 0x000B and half write to 0x0006 -> be=4'b1000, wr_addr=0x0008; be=4'b1100, wr_addr=0x0004.
- Read 0x0008 with regfile rd_rdy one cycle after rd_en, rdata=0xCAFEF00D -> two wait states; hrdata=0xCAFEF00D, hresp=0 on completion.
- Write 0xA5 to 0x0004, then read 0x0004 back-to-back -> rd_en asserts one cycle after wr_en (never the same cycle); hrdata returns the new value.
- Half write to 0x0001, and word read at haddr=ADDR_SPAN -> no wr_en/rd_en; hreadyout 0 then 1 with hresp=1 for both cycles.
- Read with rd_rdy held 0 -> after TIMEOUT_CYC=16 wait cycles, ERROR response; assert rstb low mid-RD_WAIT -> all outputs reset values immediately, FSM IDLE.
